// File: rtl/d_mem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port ids, default widths.
// No logic, no latency; no flow control of its own.
// Imported by d_mem_arbiter and rr_pick2.
package d_mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/d_mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the port that did not win last time is chosen.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the pick is consumed.
module rr_pick2
  import d_mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 && req1) ? ~last_grant
                                      : (req1 ? PORT_DBG : PORT_CPU);

endmodule

// File: rtl/d_mem_arbiter.sv
// Round-robin arbiter between CPU (port 0) and debug/loader (port 1) in front of the data memory.
// Latency: req sampled in IDLE -> one ACCESS cycle -> ack pulse in the following cycle; one access per 3 cycles.
// Backpressure: requesters hold req until their ack. D_MEM_ARB_BOUNDS_CHECK_EN enables the address range check.
module d_mem_arbiter
  import d_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [31:0]           addr0,
  input  logic [31:0]           addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

`ifdef D_MEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [1:0]            state;
  logic                  last_grant;
  logic                  grant_r;
  logic                  we_r;
  logic                  oob_r;
  logic [31:0]           addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic                  grant_valid;
  logic                  grant_id;
  logic                  sel_we;
  logic                  sel_oob;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  access_en;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = (grant_id == PORT_DBG) ? we1    : we0;
    sel_addr  = (grant_id == PORT_DBG) ? addr1  : addr0;
    sel_wdata = (grant_id == PORT_DBG) ? wdata1 : wdata0;
    // Any address bit at or above ADDR_WIDTH falls outside the memory.
    sel_oob   = BOUNDS_EN && ((sel_addr >> ADDR_WIDTH) != 32'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= PORT_DBG;
      grant_r    <= PORT_CPU;
      we_r       <= 1'b0;
      oob_r      <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_r <= grant_id;
            we_r    <= sel_we;
            oob_r   <= sel_oob;
            addr_r  <= sel_addr;
            wdata_r <= sel_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_r && !oob_r) begin
            if (grant_r == PORT_DBG) rdata1 <= mem_rdata;
            else                     rdata0 <= mem_rdata;
          end
          state <= ACK;
        end
        ACK: begin
          last_grant <= grant_r;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign access_en = (state == ACCESS) && !oob_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_write = access_en && we_r;
  assign mem_read  = access_en && !we_r;
  assign ack0      = (state == ACK) && (grant_r == PORT_CPU);
  assign ack1      = (state == ACK) && (grant_r == PORT_DBG);
  assign err       = (state == ACK) && oob_r;

endmodule

// File: doc/d_mem_arbiter.md
Name: d_mem_arbiter

Overview:
- Two-requester arbiter placed in front of the single-port data memory (32-bit address/data, asynchronous read, synchronous write on `MemWrite`, `ReadData` high-Z when `MemRead`=0).
- Port 0 is the CPU load/store stage. Port 1 is the debug/program-loader port.
- Round-robin arbitration, a registered request path and a one-cycle ack pulse per completed access.
- Sits between the datapath/loader and the data memory. It is the only block driving the memory control lines.

Parameters:
- ADDR_WIDTH, 8, memory depth = 2**ADDR_WIDTH words; must match the memory instance.
- DATA_WIDTH, 32, word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  32  word address; stable while req is high.
- wdata0 / wdata1  in  DATA_WIDTH  write data; stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_WIDTH  registered read data; valid in the ack cycle, then held until that port's next read completes.
- mem_addr  out  32  to memory Address.
- mem_wdata  out  DATA_WIDTH  to memory WriteData.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  DATA_WIDTH  from memory ReadData.
- err  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous on reset_n=0):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - ack0/1=0, rdata0/1=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, err=0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req: stay in IDLE; mem_read=mem_write=0.
  - One req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant, register grant id, addr, wdata and we, then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr/mem_wdata driven from the registered values.
  - mem_write = we_r; mem_read = ~we_r.
  - Read: capture mem_rdata into rdata of the granted port at the clock edge ending ACCESS.
  - Write: the memory commits at that same edge.
  - Next state: ACK.
- ACK:
  - ack of the granted port = 1; mem_read = mem_write = 0.
  - last_grant <= grant id; next state IDLE.
- Latency: req sampled high in IDLE at edge N → ack high during cycle N+2. Peak throughput is one access per 3 cycles.
- A req still high in the IDLE after an ack is treated as a new request. The requester drops req in the cycle after ack if it has no further work.
- Fairness: both ports requesting continuously alternate 0,1,0,1. Neither port waits more than one foreign access.
- A req dropped before its ack is a protocol violation. Once granted, the transaction still completes and acks.
- mem_write is never high outside ACCESS. mem_read and mem_write are never high together.
- Reset asserted mid-transaction aborts it immediately:
  - no ack is issued;
  - a write in ACCESS whose edge coincides with reset assertion is not guaranteed to commit.
- The address is forwarded unmodified (full 32 bits) unless the Optional Feature is enabled.

Optional Feature:
- Macro: D_MEM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE, a granted addr with any bit at position ≥ ADDR_WIDTH set is out of range.
  - For an out-of-range access, ACCESS drives mem_read=mem_write=0, the port's rdata is not updated, and ack still pulses in ACK.
  - err is a 1-cycle pulse coincident with that ack.
- Undefined:
  - No check is made and err is constant 0.
  - The address goes to the memory unchanged; an out-of-range result is the memory's behaviour.

Decomposition:
- Shared package d_mem_arb_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2);
  - the port-id constants (PORT_CPU=1'b0, PORT_DBG=1'b1);
  - the default ADDR_WIDTH and DATA_WIDTH.
- One sub-module, rr_pick2: a combinational round-robin selector.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
- The FSM, request registers and response registers stay in d_mem_arbiter.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles with req0=1 → ack0/1, mem_read, mem_write and rdata0/1 all 0; first ack0 appears 2 cycles after reset_n rises (req0 sampled at the first edge after release).
2. Single write then read, port 0:
   - Write: req0=1, we0=1, addr0=5, wdata0=32'hDEADBEEF → mem_write high for exactly one cycle, ack0 two cycles after sampling.
   - Read: req0=1, we0=0, addr0=5 → rdata0=32'hDEADBEEF in the ack0 cycle.
3. Contention: req0 and req1 both high continuously from reset, reads of addr 1 and 2 → ack order 0,1,0,1; every ack spaced 3 cycles apart.
4. Preloaded contents: memory word 7=32'h12345678 loaded by port 1 write; port 0 reads addr 7 → rdata0=32'h12345678; rdata1 unchanged by port 0's read.
5. Reset mid-op: reset_n pulled low during the ACCESS state of a port 1 write → no ack1; FSM in IDLE after release; the next req0 is served normally.
6. With D_MEM_ARB_BOUNDS_CHECK_EN and ADDR_WIDTH=8:
   - port 0 writes addr 32'h100 → mem_write stays 0, ack0 and err pulse together;
   - an addr 32'hFF write commits with err=0.
